// File: rtl/ex_mem_stage_pkg.sv
// Shared constants and types for the LEGv8 EX/MEM pipeline register:
// datapath widths, B.cond condition codes and NZCV bit positions.
package ex_mem_stage_pkg;

  localparam int WORD    = 64;
  localparam int REGADDR = 5;

  // Bit positions inside the architectural flag vector {N,Z,C,V}.
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // MEM/WB control bundle carried alongside the instruction.
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctl_t;

endpackage : ex_mem_stage_pkg

// File: rtl/ex_mem_stage_if.sv
// EX-to-MEM bus: EX-stage inputs, pipeline controls and the registered MEM-stage outputs.
// Stall holds the stage, Flush (which wins over Stall) turns the captured slot into a bubble.
interface ex_mem_stage_if;
  import ex_mem_stage_pkg::*;

  logic                 Stall;
  logic                 Flush;
  logic                 ExValid;
  logic [WORD-1:0]      ALUOut;
  logic                 Zero;
  logic                 Negative;
  logic                 Overflow;
  logic                 Co;
  logic [WORD-1:0]      StoreData;
  logic [WORD-1:0]      BranchTarget;
  logic [REGADDR-1:0]   RdIn;
  logic                 FlagSet;
  logic                 CondBranch;
  logic                 UncondBranch;
  logic                 ZeroBranch;
  logic                 NZeroBranch;
  logic [3:0]           Cond;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 RegWrite;
  logic                 MemtoReg;

  logic [WORD-1:0]      MemAddr;
  logic [WORD-1:0]      MemWData;
  logic [REGADDR-1:0]   MemRdOut;
  logic                 MemValid;
  logic                 MemReadOut;
  logic                 MemWriteOut;
  logic                 RegWriteOut;
  logic                 MemtoRegOut;
  logic                 PCSrc;
  logic [WORD-1:0]      BranchTargetOut;
  logic [3:0]           NZCV;

  // Upstream (execute stage / hazard unit) side.
  modport master (
    output Stall, Flush, ExValid, ALUOut, Zero, Negative, Overflow, Co,
           StoreData, BranchTarget, RdIn, FlagSet, CondBranch, UncondBranch,
           ZeroBranch, NZeroBranch, Cond, MemRead, MemWrite, RegWrite, MemtoReg,
    input  MemAddr, MemWData, MemRdOut, MemValid, MemReadOut, MemWriteOut,
           RegWriteOut, MemtoRegOut, PCSrc, BranchTargetOut, NZCV
  );

  // Pipeline-register side.
  modport slave (
    input  Stall, Flush, ExValid, ALUOut, Zero, Negative, Overflow, Co,
           StoreData, BranchTarget, RdIn, FlagSet, CondBranch, UncondBranch,
           ZeroBranch, NZeroBranch, Cond, MemRead, MemWrite, RegWrite, MemtoReg,
    output MemAddr, MemWData, MemRdOut, MemValid, MemReadOut, MemWriteOut,
           RegWriteOut, MemtoRegOut, PCSrc, BranchTargetOut, NZCV
  );

endinterface : ex_mem_stage_if

// File: rtl/ex_mem_stage_cond_eval.sv
// Combinational B.cond evaluator: condition code plus {N,Z,C,V} to a taken/not-taken bit.
module ex_mem_stage_cond_eval
  import ex_mem_stage_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       cond_true_o
);

  logic n, z, c, v;

  assign n = nzcv_i[NZCV_N];
  assign z = nzcv_i[NZCV_Z];
  assign c = nzcv_i[NZCV_C];
  assign v = nzcv_i[NZCV_V];

  always_comb begin
    cond_true_o = 1'b0;
    unique case (cond_e'(cond_i))
      COND_EQ: cond_true_o = z;
      COND_NE: cond_true_o = ~z;
      COND_HS: cond_true_o = c;
      COND_LO: cond_true_o = ~c;
      COND_MI: cond_true_o = n;
      COND_PL: cond_true_o = ~n;
      COND_VS: cond_true_o = v;
      COND_VC: cond_true_o = ~v;
      COND_HI: cond_true_o = c & ~z;
      COND_LS: cond_true_o = ~(c & ~z);
      COND_GE: cond_true_o = (n == v);
      COND_LT: cond_true_o = (n != v);
      COND_GT: cond_true_o = ~z & (n == v);
      COND_LE: cond_true_o = ~(~z & (n == v));
      COND_AL: cond_true_o = 1'b1;
      COND_NV: cond_true_o = 1'b1;
      default: cond_true_o = 1'b1;
    endcase
  end

endmodule : ex_mem_stage_cond_eval

// File: rtl/ex_mem_stage.sv
// LEGv8 EX/MEM pipeline register: captures ALU result, store data and MEM/WB control,
// owns the NZCV flag register and registers the resolved branch decision as PCSrc.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_stage_if.slave  bus
);

  logic [WORD-1:0]    addr_q,   addr_d;
  logic [WORD-1:0]    wdata_q,  wdata_d;
  logic [WORD-1:0]    target_q, target_d;
  logic [REGADDR-1:0] rd_q,     rd_d;
  logic               valid_q,  valid_d;
  logic               pcsrc_q,  pcsrc_d;
  ctl_t               ctl_q,    ctl_d;
  logic [3:0]         nzcv_q,   nzcv_d;

  logic cond_true;
  logic taken;
  logic capture;
  logic live;
  ctl_t ctl_in;

  // Branch condition uses the committed flags, so a FlagSet+CondBranch
  // instruction sees the previous flags rather than its own.
  ex_mem_stage_cond_eval u_cond_eval (
    .cond_i      (bus.Cond),
    .nzcv_i      (nzcv_q),
    .cond_true_o (cond_true)
  );

  assign taken = bus.UncondBranch
               | (bus.ZeroBranch  &  bus.Zero)
               | (bus.NZeroBranch & ~bus.Zero)
               | (bus.CondBranch  &  cond_true);

  assign ctl_in = '{mem_read:   bus.MemRead,
                    mem_write:  bus.MemWrite,
                    reg_write:  bus.RegWrite,
                    mem_to_reg: bus.MemtoReg};

  // Data fields load whenever the stage advances (even into a bubble);
  // control only survives when a real instruction advances.
  assign capture = bus.Flush | ~bus.Stall;
  assign live    = ~bus.Flush & ~bus.Stall & bus.ExValid;

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    target_d = target_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    pcsrc_d  = pcsrc_q;
    ctl_d    = ctl_q;
    nzcv_d   = nzcv_q;

    if (capture) begin
      addr_d   = bus.ALUOut;
      wdata_d  = bus.StoreData;
      target_d = bus.BranchTarget;
      rd_d     = bus.RdIn;
      valid_d  = live;
      pcsrc_d  = live & taken;
      ctl_d    = live ? ctl_in : '0;
    end

    if (live && bus.FlagSet) begin
      nzcv_d[NZCV_N] = bus.Negative;
      nzcv_d[NZCV_Z] = bus.Zero;
      nzcv_d[NZCV_C] = bus.Co;
      nzcv_d[NZCV_V] = bus.Overflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      target_q <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      pcsrc_q  <= 1'b0;
      ctl_q    <= '0;
      nzcv_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      target_q <= target_d;
      rd_q     <= rd_d;
      valid_q  <= valid_d;
      pcsrc_q  <= pcsrc_d;
      ctl_q    <= ctl_d;
      nzcv_q   <= nzcv_d;
    end
  end

  assign bus.MemAddr         = addr_q;
  assign bus.MemWData        = wdata_q;
  assign bus.MemRdOut        = rd_q;
  assign bus.MemValid        = valid_q;
  assign bus.MemReadOut      = ctl_q.mem_read;
  assign bus.MemWriteOut     = ctl_q.mem_write;
  assign bus.RegWriteOut     = ctl_q.reg_write;
  assign bus.MemtoRegOut     = ctl_q.mem_to_reg;
  assign bus.PCSrc           = pcsrc_q;
  assign bus.BranchTargetOut = target_q;
  assign bus.NZCV            = nzcv_q;

endmodule : ex_mem_stage

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a vector table of hand-computed results
// plus hand-written reset sequences.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs: flags = {N,Z,C,V}, br = {cond,uncond,zero,nzero},
  // ctl = {MemRead,MemWrite,RegWrite,MemtoReg}. StoreData is driven as ~alu.
  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        ev;
    logic [63:0] alu;
    logic [63:0] target;
    logic [4:0]  rd;
    logic [3:0]  flags;
    logic        fs;
    logic [3:0]  br;
    logic [3:0]  cond;
    logic [3:0]  ctl;
    logic [63:0] e_addr;
    logic [63:0] e_target;
    logic [4:0]  e_rd;
    logic        e_valid;
    logic        e_pcsrc;
    logic [3:0]  e_nzcv;
    logic [3:0]  e_ctl;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.ExValid = 1'b0;
    bus.ALUOut = '0; bus.StoreData = '0; bus.BranchTarget = '0; bus.RdIn = '0;
    bus.Negative = 1'b0; bus.Zero = 1'b0; bus.Co = 1'b0; bus.Overflow = 1'b0;
    bus.FlagSet = 1'b0; bus.CondBranch = 1'b0; bus.UncondBranch = 1'b0;
    bus.ZeroBranch = 1'b0; bus.NZeroBranch = 1'b0; bus.Cond = '0;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.RegWrite = 1'b0; bus.MemtoReg = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    if (v.ev) assert ($countones(v.br) <= 1) else $error("branch controls not one-hot");
    bus.Stall = v.stall; bus.Flush = v.flush; bus.ExValid = v.ev;
    bus.ALUOut = v.alu; bus.StoreData = ~v.alu; bus.BranchTarget = v.target; bus.RdIn = v.rd;
    {bus.Negative, bus.Zero, bus.Co, bus.Overflow} = v.flags;
    bus.FlagSet = v.fs;
    {bus.CondBranch, bus.UncondBranch, bus.ZeroBranch, bus.NZeroBranch} = v.br;
    bus.Cond = v.cond;
    {bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg} = v.ctl;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d MemAddr", i), bus.MemAddr, v.e_addr);
    chk($sformatf("v%0d MemWData", i), bus.MemWData, ~v.e_addr);
    chk($sformatf("v%0d BranchTargetOut", i), bus.BranchTargetOut, v.e_target);
    chk($sformatf("v%0d MemRdOut", i), 64'(bus.MemRdOut), 64'(v.e_rd));
    chk($sformatf("v%0d MemValid", i), 64'(bus.MemValid), 64'(v.e_valid));
    chk($sformatf("v%0d PCSrc", i), 64'(bus.PCSrc), 64'(v.e_pcsrc));
    chk($sformatf("v%0d NZCV", i), 64'(bus.NZCV), 64'(v.e_nzcv));
    chk($sformatf("v%0d ctl", i),
        64'({bus.MemReadOut, bus.MemWriteOut, bus.RegWriteOut, bus.MemtoRegOut}),
        64'(v.e_ctl));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " MemAddr"}, bus.MemAddr, 64'h0);
    chk({tag, " MemWData"}, bus.MemWData, 64'h0);
    chk({tag, " BranchTargetOut"}, bus.BranchTargetOut, 64'h0);
    chk({tag, " MemRdOut"}, 64'(bus.MemRdOut), 64'h0);
    chk({tag, " flags+ctl"},
        64'({bus.MemValid, bus.PCSrc, bus.NZCV, bus.MemReadOut, bus.MemWriteOut,
             bus.RegWriteOut, bus.MemtoRegOut}), 64'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //        stall flush ev  alu            target        rd     flags   fs    br      cond   ctl     | e_addr        e_target      e_rd   val   pc    nzcv    ctl
    vecs[0]  = '{1'b0,1'b0,1'b1, 64'h10,        64'h0,        5'd3,  4'b0000,1'b0,4'b0000,4'h0,4'b0010, 64'h10,       64'h0,        5'd3,  1'b1,1'b0,4'b0000,4'b0010};
    vecs[1]  = '{1'b0,1'b0,1'b1, 64'h0,         64'h0,        5'd5,  4'b0110,1'b1,4'b0000,4'h0,4'b0010, 64'h0,        64'h0,        5'd5,  1'b1,1'b0,4'b0110,4'b0010};
    vecs[2]  = '{1'b0,1'b0,1'b1, 64'h20,        64'h100,      5'd0,  4'b0000,1'b0,4'b1000,4'h0,4'b0000, 64'h20,       64'h100,      5'd0,  1'b1,1'b1,4'b0110,4'b0000};
    vecs[3]  = '{1'b0,1'b0,1'b1, 64'h24,        64'h104,      5'd0,  4'b0000,1'b0,4'b1000,4'h1,4'b0000, 64'h24,       64'h104,      5'd0,  1'b1,1'b0,4'b0110,4'b0000};
    vecs[4]  = '{1'b0,1'b0,1'b1, 64'h28,        64'h108,      5'd0,  4'b0000,1'b0,4'b1000,4'h2,4'b0000, 64'h28,       64'h108,      5'd0,  1'b1,1'b1,4'b0110,4'b0000};
    vecs[5]  = '{1'b0,1'b0,1'b1, 64'h2c,        64'h10c,      5'd0,  4'b0000,1'b0,4'b1000,4'h8,4'b0000, 64'h2c,       64'h10c,      5'd0,  1'b1,1'b0,4'b0110,4'b0000};
    vecs[6]  = '{1'b0,1'b0,1'b1, 64'h30,        64'h110,      5'd0,  4'b0000,1'b0,4'b1000,4'h9,4'b0000, 64'h30,       64'h110,      5'd0,  1'b1,1'b1,4'b0110,4'b0000};
    vecs[7]  = '{1'b0,1'b0,1'b1, 64'h8000_0000_0000_0000, 64'h0, 5'd7, 4'b1000,1'b1,4'b0000,4'h0,4'b0010, 64'h8000_0000_0000_0000, 64'h0, 5'd7, 1'b1,1'b0,4'b1000,4'b0010};
    vecs[8]  = '{1'b0,1'b0,1'b1, 64'h34,        64'h120,      5'd0,  4'b0000,1'b0,4'b1000,4'hB,4'b0000, 64'h34,       64'h120,      5'd0,  1'b1,1'b1,4'b1000,4'b0000};
    vecs[9]  = '{1'b0,1'b0,1'b1, 64'h38,        64'h124,      5'd0,  4'b0000,1'b0,4'b1000,4'hC,4'b0000, 64'h38,       64'h124,      5'd0,  1'b1,1'b0,4'b1000,4'b0000};
    vecs[10] = '{1'b0,1'b0,1'b1, 64'h3c,        64'h128,      5'd0,  4'b0000,1'b0,4'b1000,4'hA,4'b0000, 64'h3c,       64'h128,      5'd0,  1'b1,1'b0,4'b1000,4'b0000};
    vecs[11] = '{1'b0,1'b0,1'b1, 64'h40,        64'h12c,      5'd0,  4'b0000,1'b0,4'b1000,4'hE,4'b0000, 64'h40,       64'h12c,      5'd0,  1'b1,1'b1,4'b1000,4'b0000};
    vecs[12] = '{1'b0,1'b0,1'b1, 64'h12,        64'h200,      5'd12, 4'b0000,1'b0,4'b1000,4'h4,4'b1001, 64'h12,       64'h200,      5'd12, 1'b1,1'b1,4'b1000,4'b1001};
    vecs[13] = '{1'b1,1'b0,1'b1, 64'hdead,      64'h300,      5'd9,  4'b0100,1'b1,4'b0100,4'h0,4'b0100, 64'h12,       64'h200,      5'd12, 1'b1,1'b1,4'b1000,4'b1001};
    vecs[14] = '{1'b1,1'b0,1'b1, 64'hbeef,      64'h304,      5'd10, 4'b0100,1'b1,4'b0100,4'h0,4'b0100, 64'h12,       64'h200,      5'd12, 1'b1,1'b1,4'b1000,4'b1001};
    vecs[15] = '{1'b1,1'b0,1'b1, 64'hdead,      64'h300,      5'd9,  4'b0100,1'b1,4'b0100,4'h0,4'b0100, 64'h12,       64'h200,      5'd12, 1'b1,1'b1,4'b1000,4'b1001};
    vecs[16] = '{1'b0,1'b0,1'b1, 64'hdead,      64'h300,      5'd9,  4'b0100,1'b1,4'b0100,4'h0,4'b0100, 64'hdead,     64'h300,      5'd9,  1'b1,1'b1,4'b0100,4'b0100};
    vecs[17] = '{1'b1,1'b1,1'b1, 64'h77,        64'h400,      5'd4,  4'b1000,1'b1,4'b0100,4'h0,4'b0100, 64'h77,       64'h400,      5'd4,  1'b0,1'b0,4'b0100,4'b0000};
    vecs[18] = '{1'b0,1'b0,1'b1, 64'h30,        64'h500,      5'd2,  4'b0100,1'b0,4'b0010,4'h0,4'b0000, 64'h30,       64'h500,      5'd2,  1'b1,1'b1,4'b0100,4'b0000};
    vecs[19] = '{1'b0,1'b0,1'b1, 64'h31,        64'h600,      5'd2,  4'b0100,1'b0,4'b0001,4'h0,4'b0000, 64'h31,       64'h600,      5'd2,  1'b1,1'b0,4'b0100,4'b0000};
    vecs[20] = '{1'b0,1'b0,1'b0, 64'h40,        64'h700,      5'd6,  4'b1000,1'b1,4'b0100,4'h0,4'b0110, 64'h40,       64'h700,      5'd6,  1'b0,1'b0,4'b0100,4'b0000};
    vecs[21] = '{1'b0,1'b0,1'b1, 64'h50,        64'h800,      5'd1,  4'b0000,1'b0,4'b0001,4'h0,4'b0000, 64'h50,       64'h800,      5'd1,  1'b1,1'b1,4'b0100,4'b0000};
    vecs[22] = '{1'b0,1'b0,1'b1, 64'h54,        64'h804,      5'd0,  4'b0000,1'b0,4'b1000,4'h7,4'b0000, 64'h54,       64'h804,      5'd0,  1'b1,1'b1,4'b0100,4'b0000};
    vecs[23] = '{1'b0,1'b0,1'b1, 64'h58,        64'h808,      5'd0,  4'b0000,1'b0,4'b1000,4'h6,4'b0000, 64'h58,       64'h808,      5'd0,  1'b1,1'b0,4'b0100,4'b0000};
    vecs[24] = '{1'b0,1'b0,1'b1, 64'h5c,        64'h80c,      5'd0,  4'b0000,1'b0,4'b1000,4'h5,4'b0000, 64'h5c,       64'h80c,      5'd0,  1'b1,1'b1,4'b0100,4'b0000};
    vecs[25] = '{1'b0,1'b0,1'b1, 64'h60,        64'h810,      5'd0,  4'b0000,1'b0,4'b1000,4'h3,4'b0000, 64'h60,       64'h810,      5'd0,  1'b1,1'b1,4'b0100,4'b0000};
    vecs[26] = '{1'b0,1'b0,1'b1, 64'h64,        64'h814,      5'd0,  4'b0000,1'b0,4'b1000,4'hD,4'b0000, 64'h64,       64'h814,      5'd0,  1'b1,1'b1,4'b0100,4'b0000};
    vecs[27] = '{1'b0,1'b0,1'b1, 64'h68,        64'h818,      5'd0,  4'b0000,1'b0,4'b1000,4'hF,4'b0000, 64'h68,       64'h818,      5'd0,  1'b1,1'b1,4'b0100,4'b0000};

    // Power-on reset with a live instruction on the inputs.
    rst_n = 1'b0;
    drive_vec(vecs[0]);
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive_vec(vecs[i]);
      @(posedge clk);
      #1 check_vec(i, vecs[i]);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a stall, between clock edges.
    drive_vec(vecs[14]);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset mid-stall");

    // Asynchronous reset in the middle of a flush.
    @(negedge clk);
    rst_n = 1'b1;
    drive_vec(vecs[7]);
    @(posedge clk);
    #1 chk("pre-flush NZCV", 64'(bus.NZCV), 64'h8);
    @(negedge clk);
    drive_vec(vecs[17]);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset mid-flush");

    // First edge after release captures the waiting instruction.
    @(negedge clk);
    drive_idle();
    bus.ExValid  = 1'b1;
    bus.ALUOut   = 64'h10;
    bus.RegWrite = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset MemAddr", bus.MemAddr, 64'd16);
    chk("post-reset RegWriteOut", 64'(bus.RegWriteOut), 64'h1);
    chk("post-reset MemValid", 64'(bus.MemValid), 64'h1);
    chk("post-reset NZCV", 64'(bus.NZCV), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_ex_mem_stage

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register of the LEGv8 pipelined core. Sits directly downstream of the execute-stage ALU and feeds the data-memory stage.
- Captures the ALU result and flags, store data, destination register and MEM/WB control.
- Holds the architectural NZCV flag register, updated by flag-setting instructions (ADDS/SUBS/ANDS).
- Resolves conditional (B.cond), unconditional (B) and CBZ/CBNZ branch decisions and registers them as the MEM-stage PC-select.

Parameters:
- WORD, 64, datapath width; comes from the shared header constant WORD.
- REGADDR, 5, register-index width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  hold all stage contents, including the flags.
- Flush  in  1  replace the captured instruction with a bubble.
- ExValid  in  1  EX holds a real instruction.
- ALUOut  in  WORD  ALU result.
- Zero  in  1  ALU zero flag.
- Negative  in  1  ALU negative flag.
- Overflow  in  1  ALU signed-overflow flag.
- Co  in  1  ALU carry flag.
- StoreData  in  WORD  forwarded Rt value for STUR.
- BranchTarget  in  WORD  PC+offset computed in EX.
- RdIn  in  REGADDR  destination register.
- FlagSet  in  1  instruction writes NZCV.
- CondBranch  in  1  B.cond.
- UncondBranch  in  1  B.
- ZeroBranch  in  1  CBZ.
- NZeroBranch  in  1  CBNZ.
- Cond  in  4  B.cond condition code.
- MemRead  in  1  MEM-stage control, captured.
- MemWrite  in  1  MEM-stage control, captured.
- RegWrite  in  1  WB-stage control, captured.
- MemtoReg  in  1  WB-stage control, captured.
- MemAddr  out  WORD  registered ALUOut.
- MemWData  out  WORD  registered StoreData.
- MemRdOut  out  REGADDR  registered RdIn.
- MemValid  out  1  MEM holds a real instruction.
- MemReadOut  out  1  registered MemRead.
- MemWriteOut  out  1  registered MemWrite.
- RegWriteOut  out  1  registered RegWrite.
- MemtoRegOut  out  1  registered MemtoReg.
- PCSrc  out  1  branch taken.
- BranchTargetOut  out  WORD  registered BranchTarget.
- NZCV  out  4  architectural flags {N,Z,C,V}.

Behaviour:
- Reset (rst_n low, asynchronous): every output and every internal register clears to 0, NZCV included. Leaving reset is sampled on the first rising clk edge.
- Latency: exactly 1 cycle from EX inputs to MEM outputs; no combinational path from inputs to outputs.
- Priority at each rising edge is Flush > Stall > normal.
- Flush:
  - MemValid, MemReadOut, MemWriteOut, RegWriteOut, MemtoRegOut and PCSrc clear to 0.
  - Data fields (MemAddr, MemWData, MemRdOut, BranchTargetOut) load their inputs; they are don't-care in a bubble.
  - NZCV is unchanged.
- Stall without Flush: all registers, NZCV included, keep their values.
- Normal, ExValid=1:
  - Capture all inputs; MemValid=1.
  - If FlagSet, NZCV <= {Negative, Zero, Co, Overflow}.
- Normal, ExValid=0: treated as a bubble (same as Flush) and NZCV is unchanged.
- Taken evaluation (combinational in EX, registered into PCSrc):
  - taken = UncondBranch | (ZeroBranch & Zero) | (NZeroBranch & ~Zero) | (CondBranch & condTrue).
  - PCSrc <= taken & ExValid.
- condTrue uses the registered NZCV, i.e. the flags of the last flag-setting instruction already committed to this stage.
  - An instruction that is both FlagSet and CondBranch is illegal; in that case the old flags are used.
- Cond encoding:
  - 0 EQ: Z.  1 NE: ~Z.
  - 2 HS: C.  3 LO: ~C.
  - 4 MI: N.  5 PL: ~N.
  - 6 VS: V.  7 VC: ~V.
  - 8 HI: C&~Z.  9 LS: ~(C&~Z).
  - A GE: N==V.  B LT: N!=V.
  - C GT: ~Z&(N==V).  D LE: ~(~Z&(N==V)).
  - E and F: always.
- Control one-hot rule: at most one of CondBranch, UncondBranch, ZeroBranch, NZeroBranch may be set. The bench asserts this only when ExValid=1.
- A reset asserted mid-stall or mid-flush overrides everything immediately.

Decomposition:
- Shared header additions: condition-code constants COND_EQ through COND_AL, and the NZCV bit-index constants.
- One sub-module, cond_eval: combinational, Cond[3:0] plus NZCV[3:0] to condTrue. Reused by the top-level branch unit.

Test Plan:
- Reset: hold rst_n=0 mid-cycle -> all outputs 0 immediately, asynchronously. Release -> the first edge captures ALUOut=64'h10, RegWrite=1, giving MemAddr=16, RegWriteOut=1, MemValid=1.
- SUBS flag-set then branch:
  - SUBS with ALUOut=0, Zero=1, Co=1, FlagSet=1 -> NZCV=4'b0110.
  - Next B.cond Cond=0 (EQ) -> PCSrc=1.
  - Cond=1 (NE) instead -> PCSrc=0.
- Signed conditions: Negative=1, Overflow=0 flag-set, then Cond=B (LT) -> PCSrc=1. Same flags with Cond=C (GT) -> PCSrc=0.
- Stall hold: Stall=1 for 3 cycles while the inputs change, including FlagSet=1 -> outputs and NZCV unchanged. Deassert -> the current inputs are captured on the next edge.
- Flush vs stall: Flush=1 and Stall=1 on the same edge with MemWrite=1, UncondBranch=1 -> MemWriteOut=0, PCSrc=0, MemValid=0, NZCV unchanged.
- CBZ/CBNZ: ZeroBranch=1, Zero=1, ExValid=1 -> PCSrc=1 and BranchTargetOut=input target. NZeroBranch=1, Zero=1 -> PCSrc=0. ExValid=0 with UncondBranch=1 -> PCSrc=0.
